// File: rtl/feeder_arbiter.sv
// feeder_arbiter
//
// Round-robin scheduler that shares one downstream sample consumer between a
// bank of sample feeders. For each batch it enables every feeder and grants
// one presented sample at a time onto a registered valid/ready output. It
// acknowledges each accepted sample back to its feeder and counts NUM_SAMPLES
// deliveries per feeder. It pulses done once every feeder has delivered its
// quota.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   start          begin a batch (sampled only while idle)
//   feederValid    per-feeder sample-valid
//   feederSamples  packed samples, feeder i at [(i+1)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH]
//   feederEnable   per-feeder enable, all ones while a batch is running
//   feederReceived one-hot acknowledge, combinational with outReady
//   outSample      granted sample (registered)
//   outSource      index of the granted feeder (registered)
//   outValid       outSample/outSource valid
//   outReady       consumer accepts the presented sample
//   busy           batch in progress
//   done           one-cycle batch-complete pulse

module feeder_arbiter #(
   parameter int unsigned NUM_FEEDERS  = 4,
   parameter int unsigned NUM_SAMPLES  = 8,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [NUM_FEEDERS-1:0]              feederValid,
   input  logic [NUM_FEEDERS*SAMPLE_WIDTH-1:0] feederSamples,
   output logic [NUM_FEEDERS-1:0]              feederEnable,
   output logic [NUM_FEEDERS-1:0]              feederReceived,
   output logic [SAMPLE_WIDTH-1:0]             outSample,
   output logic [$clog2(NUM_FEEDERS)-1:0]      outSource,
   output logic                                outValid,
   input  logic                                outReady,
   output logic                                busy,
   output logic                                done
);

   localparam int unsigned SRC_W = $clog2(NUM_FEEDERS);
   localparam int unsigned CNT_W = $clog2(NUM_SAMPLES) + 1;

   localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(NUM_SAMPLES);
   localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_FEEDERS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StArb,
      StSend,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        count_q [NUM_FEEDERS];
   logic [CNT_W-1:0]        count_d [NUM_FEEDERS];
   logic [SRC_W-1:0]        ptr_q, ptr_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic [SRC_W-1:0]        source_q, source_d;

   logic [SAMPLE_WIDTH-1:0] samples [NUM_FEEDERS];
   logic [NUM_FEEDERS-1:0]  eligible;
   logic                    all_full;
   logic                    grant_found;
   logic [SRC_W-1:0]        grant_idx;
   logic [SRC_W-1:0]        cand;

   // Unpack the flat sample bus into one word per feeder.
   for (genvar g = 0; g < NUM_FEEDERS; g++) begin : g_unpack
      assign samples[g] = feederSamples[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   end

   // A feeder competes only while it presents a sample and still owes samples.
   always_comb begin
      eligible = '0;
      all_full = 1'b1;
      for (int unsigned i = 0; i < NUM_FEEDERS; i++) begin
         eligible[i] = feederValid[i] && (count_q[i] < COUNT_MAX);
         if (count_q[i] != COUNT_MAX) begin
            all_full = 1'b0;
         end
      end
   end

   // Round-robin pick: first eligible feeder scanning ptr, ptr+1, ... wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_FEEDERS; k++) begin
         cand = SRC_W'((32'(ptr_q) + k) % NUM_FEEDERS);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      ptr_d          = ptr_q;
      sample_d       = sample_q;
      source_d       = source_q;
      feederEnable   = '0;
      feederReceived = '0;
      outValid       = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               for (int unsigned i = 0; i < NUM_FEEDERS; i++) begin
                  count_d[i] = '0;
               end
               ptr_d   = '0;
               state_d = StArb;
            end
         end

         StArb: begin
            busy         = 1'b1;
            feederEnable = '1;
            if (all_full) begin
               state_d = StDone;
            end else if (grant_found) begin
               sample_d = samples[grant_idx];
               source_d = grant_idx;
               state_d  = StSend;
            end
         end

         StSend: begin
            busy         = 1'b1;
            feederEnable = '1;
            outValid     = 1'b1;
            if (outReady) begin
               // The acknowledge is suppressed under reset, since the handshake will not
               // complete. The count guard keeps a full feeder from ever being acknowledged.
               if (count_q[source_q] < COUNT_MAX) begin
                  feederReceived[source_q] = !rst;
                  count_d[source_q]        = count_q[source_q] + 1'b1;
               end
               ptr_d   = (source_q == LAST_SRC) ? '0 : source_q + 1'b1;
               state_d = StArb;
            end
         end

         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         sample_q <= '0;
         source_q <= '0;
         for (int unsigned i = 0; i < NUM_FEEDERS; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sample_q <= sample_d;
         source_q <= source_d;
         count_q  <= count_d;
      end
   end

   assign outSample = sample_q;
   assign outSource = source_q;

endmodule

// File: tb/tb_feeder_arbiter.sv
// Testbench for feeder_arbiter with 4 feeders and 2 samples per feeder.
// Directed scenarios: reset/idle, a full batch, backpressure, skipping of
// invalid feeders, exhaustion of one feeder, and reset in the middle of a batch.

module tb_feeder_arbiter;

   localparam int unsigned NF   = 4;
   localparam int unsigned NS   = 2;
   localparam int unsigned SW   = 16;
   localparam int unsigned SRCW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [NF-1:0]    feederValid;
   logic [NF*SW-1:0] feederSamples;
   logic [NF-1:0]    feederEnable;
   logic [NF-1:0]    feederReceived;
   logic [SW-1:0]    outSample;
   logic [SRCW-1:0]  outSource;
   logic             outValid;
   logic             outReady;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int done_cnt;
   int done_cyc;
   int spurious;
   int grants[$];

   always #5 clk = ~clk;

   feeder_arbiter #(
      .NUM_FEEDERS (NF),
      .NUM_SAMPLES (NS),
      .SAMPLE_WIDTH(SW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .feederValid   (feederValid),
      .feederSamples (feederSamples),
      .feederEnable  (feederEnable),
      .feederReceived(feederReceived),
      .outSample     (outSample),
      .outSource     (outSource),
      .outValid      (outValid),
      .outReady      (outReady),
      .busy          (busy),
      .done          (done)
   );

   function automatic logic [SW-1:0] feeder_word(input int i);
      return 16'hC0DE ^ SW'(i * 32'h1111);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records accepted grants, checks the acknowledge and sample of each, and
   // tallies done pulses and stray acknowledges.
   task automatic observe();
      if (outValid && outReady) begin
         grants.push_back(int'(outSource));
         check("recv_onehot", 32'(feederReceived), 32'(1) << outSource);
         check("sample", 32'(outSample), 32'(feeder_word(int'(outSource))));
      end else if (feederReceived != '0) begin
         spurious++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic start_batch();
      grants.delete();
      done_cnt = 0;
      done_cyc = 0;
      spurious = 0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      cyc      = 1;
      observe();
   endtask

   task automatic run(input int n, input bit stop_on_done);
      for (int i = 0; i < n; i++) begin
         if (stop_on_done && done_cnt != 0) break;
         tick();
         cyc++;
         observe();
      end
   endtask

   // seq packs expected sources 4 bits each, first grant in the most significant used nibble.
   task automatic check_seq(input string tag, input int len, input logic [31:0] seq);
      check({tag, "_len"}, grants.size(), len);
      for (int k = 0; k < len && k < grants.size(); k++) begin
         check(tag, grants[k], 32'(seq[4*(len-1-k) +: 4]));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 32'({outValid, busy, done, feederEnable, feederReceived, outSource, outSample}),
            32'h0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      outReady    = 1'b0;
      feederValid = '0;
      for (int i = 0; i < NF; i++) begin
         feederSamples[i*SW +: SW] = feeder_word(i);
      end

      // Reset and idle
      tick();
      tick();
      check_all_zero("reset_outputs");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_all_zero("idle_outputs");
      end

      // Full batch, all valid, consumer always ready
      feederValid = '1;
      outReady    = 1'b1;
      start_batch();
      check("arb_enable", 32'(feederEnable), 32'hF);
      check("arb_busy", 32'(busy), 32'h1);
      check("arb_no_valid", 32'(outValid), 32'h0);
      run(30, 1'b1);
      check_seq("full_seq", 8, 32'h01230123);
      check("full_done_cnt", done_cnt, 1);
      check("full_done_cyc", done_cyc, 18);
      check("full_spurious", spurious, 0);
      tick();
      check("full_idle_busy", 32'(busy), 32'h0);
      check("full_idle_done", 32'(done), 32'h0);
      check("full_idle_enable", 32'(feederEnable), 32'h0);

      // Backpressure: sample held while the consumer stalls
      outReady = 1'b0;
      start_batch();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(outValid), 32'h1);
         check("bp_source", 32'(outSource), 32'h0);
         check("bp_sample", 32'(outSample), 32'(feeder_word(0)));
         check("bp_no_recv", 32'(feederReceived), 32'h0);
         tick();
      end
      outReady = 1'b1;
      #1;
      check("bp_recv", 32'(feederReceived), 32'h1);
      observe();
      run(40, 1'b1);
      check_seq("bp_seq", 8, 32'h01230123);
      check("bp_done_cnt", done_cnt, 1);
      check("bp_spurious", spurious, 0);
      tick();

      // Skipping: only feeders 1 and 3 valid, then the rest join
      feederValid = 4'b1010;
      start_batch();
      run(20, 1'b0);
      check_seq("skip_seq", 4, 32'h00001313);
      check("skip_no_done", done_cnt, 0);
      check("skip_busy", 32'(busy), 32'h1);
      check("skip_spurious", spurious, 0);
      feederValid = '1;
      grants.delete();
      run(30, 1'b1);
      check_seq("skip_rest", 4, 32'h00000202);
      check("skip_done_cnt", done_cnt, 1);
      tick();

      // Exhaustion: feeder 0 fills up and is never granted again
      feederValid = 4'b0001;
      start_batch();
      run(12, 1'b0);
      check_seq("exh_first", 2, 32'h00000000);
      check("exh_no_done", done_cnt, 0);
      feederValid = '1;
      grants.delete();
      run(40, 1'b1);
      check_seq("exh_rest", 6, 32'h00123123);
      check("exh_done_cnt", done_cnt, 1);
      check("exh_spurious", spurious, 0);
      tick();

      // Reset in the middle of a batch, during SEND with outReady high
      outReady = 1'b0;
      start_batch();
      tick();
      check("mrst_in_send", 32'(outValid), 32'h1);
      outReady = 1'b1;
      rst      = 1'b1;
      #1;
      check("mrst_no_recv", 32'(feederReceived), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      check_all_zero("mrst_outputs");
      start_batch();
      run(30, 1'b1);
      check_seq("mrst_seq", 8, 32'h01230123);
      check("mrst_done_cyc", done_cyc, 18);
      check("mrst_spurious", spurious, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/feeder_arbiter.md
# feeder_arbiter

Round-robin scheduler that shares one downstream sample consumer between NUM_FEEDERS sample_feeder instances. It enables every feeder for one batch and grants one feeder-presented sample at a time onto a single registered valid/ready output port. It returns the per-feeder `received` acknowledge, counts NUM_SAMPLES deliveries per feeder, and signals batch completion. It sits between the feeder bank and the shared compute stage.

## Interface
- NUM_FEEDERS, 4: number of feeders arbitrated (≥2).
- NUM_SAMPLES, 8: samples each feeder delivers per batch (≥1).
- SAMPLE_WIDTH, 16: bits per sample (feeder SAMPLE_SIZE*DATA_SIZE).
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin batch; sampled only in IDLE.
- feederValid  in  NUM_FEEDERS  per-feeder isValid.
- feederSamples  in  NUM_FEEDERS*SAMPLE_WIDTH  feeder i occupies bits [(i+1)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH].
- feederEnable  out  NUM_FEEDERS  per-feeder enable.
- feederReceived  out  NUM_FEEDERS  one-hot acknowledge, combinational.
- outSample  out  SAMPLE_WIDTH  granted sample, registered.
- outSource  out  $clog2(NUM_FEEDERS)  index of the granted feeder, registered.
- outValid  out  1  outSample/outSource valid.
- outReady  in  1  consumer accepts.
- busy  out  1  batch in progress.
- done  out  1  one-cycle batch-complete pulse.

## Operation
- FSM states: IDLE, ARB, SEND, DONE.
- IDLE:
  - busy=0; feederEnable=0.
  - start=1 → clear all counts, set ptr=0, go to ARB.
- ARB:
  - busy=1; feederEnable=all ones.
  - Eligible feeder: feederValid[i]=1 and count[i]<NUM_SAMPLES.
  - If every count[i]==NUM_SAMPLES → DONE.
  - Else pick the first eligible index scanning ptr, ptr+1, … mod NUM_FEEDERS.
    - Latch that feeder's sample into outSample and its index into outSource; go to SEND.
  - No eligible feeder → stay in ARB.
- SEND:
  - outValid=1; outSample and outSource held stable.
  - outReady=1 → feederReceived[outSource]=1 in the same cycle (all other bits 0).
    - count[outSource] increments.
    - ptr = (outSource+1) mod NUM_FEEDERS.
    - Go to ARB.
  - outReady=0 → stay in SEND.
- DONE:
  - done=1 for exactly this cycle; feederEnable=0; busy=1.
  - Go to IDLE unconditionally.
- Per-feeder counters are $clog2(NUM_SAMPLES)+1 bits wide and never exceed NUM_SAMPLES.
- feederReceived is asserted only in SEND with outReady=1. It is never asserted to a feeder whose count is already NUM_SAMPLES.

## Timing
- Reset values:
  - State IDLE; counts 0; ptr 0.
  - outSample=0, outSource=0, outValid=0, feederEnable=0, feederReceived=0, busy=0, done=0.
- Reset is synchronous and overrides everything, including mid-batch. The next cycle is IDLE with all outputs at reset values, and no feederReceived pulse is issued that cycle.
- start accepted at edge t:
  - feederEnable=all ones from cycle t+1 (ARB).
  - First outValid no earlier than cycle t+2.
- Throughput: ≥2 cycles per sample (ARB + SEND); maximum 1 sample per 2 cycles with outReady held at 1.
- The acknowledged feeder drops feederValid for one cycle after received. That cycle coincides with ARB, so the rotating pointer alone guarantees fairness.
- Once latched in ARB, the sample is delivered even if feederValid for that feeder deasserts during SEND.
- start while busy=1: ignored.
- start held high through DONE: a new batch begins in the IDLE cycle after DONE.
- Batch latency with outReady=1 and all feeders always valid: 1 (ARB entry) + 2*NUM_FEEDERS*NUM_SAMPLES + 1 (final ARB) cycles → done.

## Test plan
- Reset/idle: rst high for 2 cycles, then start=0 for 10 cycles → all outputs 0, state IDLE throughout.
- Full batch, NUM_FEEDERS=4, NUM_SAMPLES=2, all valid, outReady=1:
  - outSource sequence is 0,1,2,3,0,1,2,3.
  - One feederReceived pulse per SEND.
  - done pulses exactly once, 18 cycles after start is accepted.
- Backpressure: outReady=0 for 5 cycles during SEND → outValid, outSample and outSource stay constant and feederReceived=0. Raising outReady gives exactly one pulse.
- Skipping: only feeders 1 and 3 valid → grants alternate 1,3,1,3. Feeders 0 and 2 are never acknowledged, and done is not asserted until they deliver.
- Exhaustion: feeder 0 reaches NUM_SAMPLES while still valid → it is never granted again; the others continue until done.
- Mid-batch reset: rst asserted during SEND with outReady=1 → no feederReceived that cycle, outputs return to reset values, and a fresh start restarts counts from 0.
